preg_release_queue: RTL
=======================

// Module: preg_release_queue
// PURPOSE
//   Retire-side return path of the physical-register freelist. Each cycle, up to
//   RET_WIDTH retiring instructions hand over their old physical tag (Told).
//   Tags are buffered in a circular queue and drained at most DRAIN_WIDTH per
//   cycle into a registered one-hot free_mask, which drives the freelist clear
//   input. Bounding the drain rate limits per-cycle fanout into the allocator.
// PARAMETERS
//   RET_WIDTH   = `N                 retire lanes per cycle
//   DRAIN_WIDTH = `N                 max tags released per cycle
//   PR_COUNT    = `PHYS_REG_SZ_R10K  physical registers; PR_IDX_W = $clog2(PR_COUNT)
//   DEPTH       = 2*`N               queue entries; DEPTH >= RET_WIDTH
// PORTS
//   clock         in   1                      system clock
//   reset         in   1                      async, active-high
//   retire_valid  in   RET_WIDTH              lane i retires and returns a tag
//   retire_told   in   RET_WIDTH x PR_IDX_W   old physical tag per lane
//   retire_stall  out  1                      retire must not assert any lane valid
//   free_mask     out  PR_COUNT               one-hot-per-tag release mask to freelist
//   count         out  $clog2(DEPTH+1)        occupied entries
//   overflow_err  out  1                      sticky: a tag was dropped for lack of space
// BEHAVIOUR
//   - Clocking and reset: one clock. Reset is asynchronous and active-high.
//     Reset forces head = tail = count = 0, free_mask = 0 and overflow_err = 0.
//     retire_stall then reads 0 because count = 0.
//   - Reset mid-operation discards all buffered tags. The freelist reseeds on the
//     same reset, so the discarded tags are not lost.
//   - Enqueue:
//     - Valid lanes are compacted in ascending lane order and written at tail.
//       tail and count advance by the number of accepted tags.
//     - Lanes with retire_told == 0 are filtered. PR 0 is the hardwired-zero
//       mapping and is never freed.
//   - Stall: retire_stall = (count > DEPTH - RET_WIDTH). It is combinational from
//     registered count only, with no dependence on retire_valid.
//   - Overflow (protocol violation): if free space is insufficient, lanes are
//     accepted in lane order until the queue is full. Remaining lanes are dropped
//     and overflow_err sets. overflow_err clears only on reset.
//   - Drain:
//     - Each cycle, n = min(count, DRAIN_WIDTH) entries are popped from head.
//       Popped entries are the ones resident at the start of the cycle; there is
//       no same-cycle bypass from retire.
//     - Next-cycle free_mask is the OR of the one-hot bits of the popped tags, or
//       0 when n = 0.
//     - free_mask is registered and holds each tag for exactly one cycle.
//   - Latency: a tag presented in cycle t is written on edge t+1. It is popped in
//     cycle t+1 at the earliest and appears in free_mask during cycle t+2.
//   - Count arithmetic: enqueue and drain happen in the same cycle, so
//     count_next = count + accepted - n.
//   - Pointers wrap modulo DEPTH; they are non-power-of-2 safe via explicit
//     compare-and-wrap.
//   - Ordering: tags leave in retire order. FIFO order is preserved across wrap.
//   - Duplicate tags in one drain batch are not expected (R10K invariant). If they
//     occur, they OR into a single bit.
//   - There is no mispredict or flush input: retired Told tags are committed and
//     always drain.
//   - Empty: free_mask = 0 and head is unchanged.
//   - Full: count = DEPTH, so retire_stall = 1. Drain continues normally.
// TESTING
//   1. Reset with 3 tags buffered -> count=0, free_mask=0, stall=0. Cycle after
//      release: no stale bits.
//   2. N=2: lanes {v=1,told=5},{v=1,told=9} in cycle 0 -> free_mask bits 5 and 9
//      set in cycle 2 only, 0 in cycles 1 and 3.
//   3. Lane told=0, lane1 told=7 -> only bit 7 ever asserts; count peaks at 1.
//   4. DRAIN_WIDTH=1: retire 2 tags/cycle for 4 cycles -> count ramps, stall
//      asserts when count>DEPTH-2. Tags exit one per cycle in retire order;
//      overflow_err stays 0.
//   5. Ignore stall at count=DEPTH with 2 valid lanes -> both dropped,
//      overflow_err=1 and sticky until reset.
//   6. Run 3*DEPTH tags through sustained enqueue+drain -> every tag released
//      exactly once, in order, across pointer wrap.

Source files
------------

// File: rtl/preg_release_queue.sv
// Retire-side return path of the physical-register freelist: buffers retiring
// Told tags in a circular queue and releases at most DRAIN_WIDTH per cycle.
module preg_release_queue #(
    parameter int RET_WIDTH   = 2,
    parameter int DRAIN_WIDTH = 2,
    parameter int PR_COUNT    = 64,
    parameter int DEPTH       = 2 * RET_WIDTH,
    localparam int PR_IDX_W   = $clog2(PR_COUNT),
    localparam int CNT_W      = $clog2(DEPTH + 1),
    localparam int PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [RET_WIDTH-1:0]                retire_valid,
    input  logic [RET_WIDTH-1:0][PR_IDX_W-1:0]  retire_told,
    output logic                                retire_stall,
    output logic [PR_COUNT-1:0]                 free_mask,
    output logic [CNT_W-1:0]                    count,
    output logic                                overflow_err
);

    logic [PR_IDX_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]    head_r;
    logic [PTR_W-1:0]    tail_r;
    logic [CNT_W-1:0]    count_r;
    logic [PR_COUNT-1:0] free_mask_r;
    logic                overflow_r;

    logic [PTR_W-1:0]    head_next_s;
    logic [PTR_W-1:0]    tail_next_s;
    logic [CNT_W-1:0]    space_s;
    logic [CNT_W-1:0]    acc_s;
    logic [CNT_W-1:0]    pop_s;
    logic                drop_s;
    logic [RET_WIDTH-1:0] lane_we_s;
    logic [PTR_W-1:0]    lane_addr_s [RET_WIDTH];
    logic [PR_COUNT-1:0] mask_next_s;

    // Explicit compare-and-wrap keeps non-power-of-2 depths correct.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] nxt;
        if (ptr == PTR_W'(DEPTH - 1)) begin
            nxt = {PTR_W{1'b0}};
        end else begin
            nxt = ptr + PTR_W'(1);
        end
        return nxt;
    endfunction

    // Enqueue: compact valid non-zero lanes in lane order into the free space.
    always_comb begin
        lane_we_s   = {RET_WIDTH{1'b0}};
        acc_s       = {CNT_W{1'b0}};
        drop_s      = 1'b0;
        tail_next_s = tail_r;
        space_s     = CNT_W'(DEPTH) - count_r;
        for (int i = 0; i < RET_WIDTH; i++) begin
            lane_addr_s[i] = {PTR_W{1'b0}};
        end
        for (int i = 0; i < RET_WIDTH; i++) begin
            if (retire_valid[i] && (retire_told[i] != {PR_IDX_W{1'b0}})) begin
                if (acc_s < space_s) begin
                    lane_we_s[i]   = 1'b1;
                    lane_addr_s[i] = tail_next_s;
                    tail_next_s    = ptr_inc(tail_next_s);
                    acc_s          = acc_s + CNT_W'(1);
                end else begin
                    drop_s = 1'b1;
                end
            end else begin
                lane_we_s[i] = 1'b0;
            end
        end
    end

    // Drain: pop up to DRAIN_WIDTH entries resident at the start of the cycle.
    always_comb begin
        mask_next_s = {PR_COUNT{1'b0}};
        head_next_s = head_r;
        pop_s       = (count_r > CNT_W'(DRAIN_WIDTH)) ? CNT_W'(DRAIN_WIDTH) : count_r;
        for (int j = 0; j < DRAIN_WIDTH; j++) begin
            if (CNT_W'(j) < pop_s) begin
                mask_next_s[mem_r[head_next_s]] = 1'b1;
                head_next_s = ptr_inc(head_next_s);
            end else begin
                head_next_s = head_next_s;
            end
        end
    end

    // Tag storage; contents are don't-care outside the head..tail window.
    always_ff @(posedge clock) begin
        for (int i = 0; i < RET_WIDTH; i++) begin
            if (lane_we_s[i]) begin
                mem_r[lane_addr_s[i]] <= retire_told[i];
            end
        end
    end

    // Pointers, occupancy, release mask and sticky overflow flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_r      <= {PTR_W{1'b0}};
            tail_r      <= {PTR_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            free_mask_r <= {PR_COUNT{1'b0}};
            overflow_r  <= 1'b0;
        end else begin
            head_r      <= head_next_s;
            tail_r      <= tail_next_s;
            count_r     <= count_r + acc_s - pop_s;
            free_mask_r <= mask_next_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

    // Stall depends on registered occupancy only, never on retire_valid.
    assign retire_stall = (count_r > CNT_W'(DEPTH - RET_WIDTH));
    assign free_mask    = free_mask_r;
    assign count        = count_r;
    assign overflow_err = overflow_r;

endmodule
